// File: rtl/dac_controller_pkg.sv
// Shared constants, state encoding and frame builder for the DAC8568 serial writer.
package dac_controller_pkg;

    localparam logic [3:0]  CMD_WRITE_UPD = 4'h3;
    localparam logic [31:0] INIT_FRAME    = 32'h0800_0001;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    function automatic logic [31:0] make_frame(input logic [3:0] ch, input logic [15:0] code);
        return {4'h0, CMD_WRITE_UPD, ch, code, 4'h0};
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Round-robin pick: first pending channel at or after rr_ptr, wrapping.
module dac_rr_arbiter #(
    parameter int N_CHAN = 8,
    parameter int W_CH   = 3
) (
    input  logic [N_CHAN-1:0] pend,
    input  logic [W_CH-1:0]   rr_ptr,
    output logic [W_CH-1:0]   grant,
    output logic              grant_valid
);

    function automatic logic [W_CH-1:0] wrap_idx(input logic [W_CH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CHAN) s = s - N_CHAN;
        return W_CH'(s);
    endfunction

    // Walk from the farthest offset down so the nearest pending channel wins.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (pend[wrap_idx(rr_ptr, i)]) begin
                grant       = wrap_idx(rr_ptr, i);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_controller.sv
// Buffers the newest code per channel and shifts 32-bit write-and-update frames to
// a DAC8568-class DAC; an internal-reference enable frame is sent after every reset.
//
//   state    | meaning
//   ST_INIT  | load the reference-enable frame
//   ST_IDLE  | wait for a pending channel, load its frame
//   ST_SHIFT | n_sync low, one bit per clk_in, MSB first
//   ST_GAP   | n_sync high for SYNC_HIGH cycles; done pulse on the first
module dac_controller
    import dac_controller_pkg::*;
#(
    parameter int W_DATA    = 16,
    parameter int N_CHAN    = 8,
    parameter int W_FRAME   = 32,
    parameter int SYNC_HIGH = 2,
    parameter bit SIGNED_IN = 1'b1,
    localparam int W_CH     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              valid_in,
    input  logic [W_CH-1:0]   chan_in,
    input  logic [W_DATA-1:0] data_in,
    output logic              sclk_out,
    output logic              n_sync_out,
    output logic              din_out,
    output logic              n_ldac_out,
    output logic              n_clr_out,
    output logic              busy_out,
    output logic [N_CHAN-1:0] write_done_out
);

    localparam int W_GAP = $clog2(SYNC_HIGH + 1);
    localparam logic [W_DATA-1:0] SIGN_BIT = {1'b1, {(W_DATA-1){1'b0}}};

    state_t              state, state_nxt;
    logic [N_CHAN-1:0]   pend, pend_nxt;
    logic [W_DATA-1:0]   code_buf [N_CHAN];
    logic [W_CH-1:0]     rr_ptr, rr_nxt, cur_ch, grant;
    logic                grant_valid, load_ch;
    logic [W_FRAME-1:0]  shreg;
    logic [4:0]          bit_cnt;
    logic [W_GAP-1:0]    gap_cnt;
    logic                init_flag;
    logic                wr_ok;
    logic [W_DATA-1:0]   wr_code;

    assign wr_ok   = valid_in && (int'(chan_in) < N_CHAN);
    assign wr_code = SIGNED_IN ? (data_in ^ SIGN_BIT) : data_in;
    assign rr_nxt  = (int'(grant) == N_CHAN - 1) ? '0 : grant + W_CH'(1);

    dac_rr_arbiter #(
        .N_CHAN (N_CHAN),
        .W_CH   (W_CH)
    ) u_arb (
        .pend        (pend),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    always_comb begin
        state_nxt = state;
        load_ch   = 1'b0;
        case (state)
            ST_INIT:  state_nxt = ST_SHIFT;
            ST_IDLE: begin
                if (grant_valid) begin
                    state_nxt = ST_SHIFT;
                    load_ch   = 1'b1;
                end
            end
            ST_SHIFT: if (bit_cnt == 5'(W_FRAME - 1)) state_nxt = ST_GAP;
            ST_GAP:   if (gap_cnt == W_GAP'(SYNC_HIGH - 1)) state_nxt = ST_IDLE;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // A new write in the load cycle re-arms the channel: the set is applied last.
    always_comb begin
        pend_nxt = pend;
        if (load_ch) pend_nxt[grant] = 1'b0;
        if (wr_ok)   pend_nxt[chan_in] = 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state     <= ST_INIT;
            pend      <= '0;
            for (int i = 0; i < N_CHAN; i++) code_buf[i] <= '0;
            rr_ptr    <= '0;
            cur_ch    <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            init_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            if (wr_ok) code_buf[chan_in] <= wr_code;
            case (state)
                ST_INIT: begin
                    shreg     <= INIT_FRAME;
                    bit_cnt   <= '0;
                    init_flag <= 1'b1;
                end
                ST_IDLE: begin
                    if (load_ch) begin
                        shreg     <= make_frame(4'(grant), code_buf[grant]);
                        cur_ch    <= grant;
                        rr_ptr    <= rr_nxt;
                        bit_cnt   <= '0;
                        init_flag <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg   <= {shreg[W_FRAME-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 5'd1;
                    gap_cnt <= '0;
                end
                ST_GAP:  gap_cnt <= gap_cnt + W_GAP'(1);
                default: ;
            endcase
        end
    end

    assign n_sync_out = (state != ST_SHIFT);
    assign din_out    = (state == ST_SHIFT) && shreg[W_FRAME-1];
    // Behavioural stand-in for the ODDR2 forwarder (D0=1, D1=0, set while sync high).
    assign sclk_out   = n_sync_out | clk_in;
    assign n_ldac_out = 1'b0;
    assign n_clr_out  = ~reset_in;
    assign busy_out   = (state != ST_IDLE) || (|pend);

    always_comb begin
        write_done_out = '0;
        if (state == ST_GAP && gap_cnt == '0 && !init_flag) write_done_out[cur_ch] = 1'b1;
    end

endmodule

// File: tb/tb_dac_controller.sv
// Self-checking bench for dac_controller: transaction-level reference model with a
// per-cycle output compare, captured-frame log, and literal directed checks.
module tb_dac_controller;
    import dac_controller_pkg::*;

    localparam int SH = 2;

    logic        clk_in   = 1'b0;
    logic        reset_in = 1'b1;
    logic        valid_in = 1'b0;
    logic [2:0]  chan_in  = '0;
    logic [15:0] data_in  = '0;
    logic        sclk_out, n_sync_out, din_out, n_ldac_out, n_clr_out, busy_out;
    logic [7:0]  write_done_out;

    dac_controller #(.SYNC_HIGH(SH)) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .valid_in       (valid_in),
        .chan_in        (chan_in),
        .data_in        (data_in),
        .sclk_out       (sclk_out),
        .n_sync_out     (n_sync_out),
        .din_out        (din_out),
        .n_ldac_out     (n_ldac_out),
        .n_clr_out      (n_clr_out),
        .busy_out       (busy_out),
        .write_done_out (write_done_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int prints = 0;

    // Reference model: t counts cycles since a frame was loaded (0 = idle slot).
    int          cyc = 0;
    bit          m_valid = 1'b0;
    logic [7:0]  m_pend;
    logic [15:0] m_buf [8];
    int          m_rr, m_t, m_ch, m_c;
    bit          m_force_init, m_is_init, m_found;
    logic [31:0] m_frame;

    always @(posedge clk_in) begin
        cyc++;
        if (reset_in) begin
            m_pend = '0;
            for (int i = 0; i < 8; i++) m_buf[i] = '0;
            m_rr = 0; m_t = 0; m_ch = 0;
            m_force_init = 1'b1; m_is_init = 1'b0; m_frame = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_t == 0) begin
                if (m_force_init) begin
                    m_frame = 32'h0800_0001; m_is_init = 1'b1; m_force_init = 1'b0; m_t = 1;
                end else begin
                    m_found = 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        m_c = (m_rr + i) % 8;
                        if (!m_found && m_pend[m_c]) begin
                            m_found = 1'b1;
                            m_ch = m_c;
                        end
                    end
                    if (m_found) begin
                        m_frame = {8'h03, 4'(m_ch), m_buf[m_ch], 4'h0};
                        m_pend[m_ch] = 1'b0;
                        m_rr = (m_ch + 1) % 8;
                        m_is_init = 1'b0;
                        m_t = 1;
                    end
                end
            end else if (m_t == 32 + SH) begin
                m_t = 0;
            end else begin
                m_t++;
            end
            if (valid_in) begin
                m_pend[chan_in] = 1'b1;
                m_buf[chan_in] = data_in ^ 16'h8000;
            end
        end
    end

    // Per-cycle compare plus frame capture and timing monitors.
    logic [31:0] cap;
    int          cap_bits = 0;
    logic [31:0] cap_log [$];
    bit          prev_ns = 1'b1;
    int          fall_cyc = 0, rise_cyc = 0, done_cyc = 0, done_count = 0, min_gap = 1000;
    logic [7:0]  done_val = '0;
    logic [12:0] act_v, exp_v;
    bit          e_ns;

    always @(negedge clk_in) begin
        if (m_valid) begin
            e_ns  = !(m_t >= 1 && m_t <= 32);
            exp_v = {e_ns, (!e_ns) ? m_frame[32 - m_t] : 1'b0, e_ns,
                     (m_t != 0) || m_force_init || (m_pend != 0),
                     (m_t == 33 && !m_is_init) ? 8'(1 << m_ch) : 8'h00,
                     1'b0, ~reset_in};
            act_v = {n_sync_out, din_out, sclk_out, busy_out, write_done_out, n_ldac_out, n_clr_out};
            tests++;
            if (act_v !== exp_v) begin
                fails++;
                if (prints < 30) begin
                    prints++;
                    $display("FAIL cycle %0d outputs {nsync,din,sclk,busy,done,nldac,nclr}: got %b required %b",
                             cyc, act_v, exp_v);
                end
            end
            if (write_done_out != 8'h00) begin
                done_count++; done_cyc = cyc; done_val = write_done_out;
            end
        end
        if (n_sync_out === 1'b0) begin
            cap = {cap[30:0], din_out};
            cap_bits++;
            if (prev_ns) begin
                fall_cyc = cyc;
                if (cyc - rise_cyc < min_gap) min_gap = cyc - rise_cyc;
            end
            prev_ns = 1'b0;
        end else begin
            if (!prev_ns) begin
                rise_cyc = cyc;
                if (cap_bits == 32) cap_log.push_back(cap);
            end
            cap_bits = 0;
            prev_ns = 1'b1;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [2:0] ch, input logic [15:0] d);
        valid_in = 1'b1; chan_in = ch; data_in = d;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (busy_out !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_idle_timeout"}, 32'(n < bound), 32'd1);
    endtask

    int c0, n0, ch5_frames;

    initial begin
        // Reset values and the init frame.
        tick(); tick();
        chk("rst_values", {27'd0, n_sync_out, din_out, sclk_out, busy_out, 1'b0},
            {27'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
        chk("rst_done", 32'(write_done_out), 32'h0);
        done_count = 0;
        reset_in = 1'b0;
        wait_idle("init", 200);
        chk("init_count", cap_log.size(), 1);
        chk("init_frame", cap_log[cap_log.size() - 1], 32'h0800_0001);
        chk("init_no_done", done_count, 0);
        chk("init_busy", 32'(busy_out), 32'h0);

        // Single write latency and frame content.
        tick();
        c0 = cyc; n0 = cap_log.size();
        send(3'd3, 16'h1234);
        wait_idle("ch3", 200);
        chk("ch3_frame", cap_log[cap_log.size() - 1], 32'h0339_2340);
        chk("ch3_sync_fall", fall_cyc - c0, 2);
        chk("ch3_sync_rise", rise_cyc - c0, 34);
        chk("ch3_done_cyc", done_cyc - c0, 34);
        chk("ch3_done_val", 32'(done_val), 32'h08);

        // Overwrite of a pending channel while busy.
        n0 = cap_log.size();
        send(3'd0, 16'h4444);
        tick(); tick(); tick();
        send(3'd5, 16'h0100);
        tick();
        send(3'd5, 16'h0200);
        wait_idle("ovr", 300);
        chk("ovr_count", cap_log.size() - n0, 2);
        chk("ovr_ch0", cap_log[n0], 32'h030C_4440);
        ch5_frames = 0;
        for (int i = n0; i < cap_log.size(); i++) if (cap_log[i][23:20] == 4'd5) ch5_frames++;
        chk("ovr_ch5_once", ch5_frames, 1);
        chk("ovr_ch5_frame", cap_log[cap_log.size() - 1], 32'h0358_2000);

        // Round-robin order from rr_ptr=2 and back-to-back gap width.
        n0 = cap_log.size();
        send(3'd1, 16'h1111);
        min_gap = 1000;
        tick(); tick();
        send(3'd0, 16'h2000);
        send(3'd1, 16'h3000);
        send(3'd7, 16'h5000);
        wait_idle("rr", 400);
        chk("rr_count", cap_log.size() - n0, 4);
        chk("rr_first_ch7", cap_log[n0 + 1], 32'h037D_0000);
        chk("rr_second_ch0", cap_log[n0 + 2], 32'h030A_0000);
        chk("rr_third_ch1", cap_log[n0 + 3], 32'h031B_0000);
        chk("rr_min_gap", min_gap, SH + 1);

        // Write to a channel in its own load cycle gives old then new frame.
        n0 = cap_log.size();
        send(3'd2, 16'h7000);
        send(3'd2, 16'h0001);
        wait_idle("coll", 300);
        chk("coll_count", cap_log.size() - n0, 2);
        chk("coll_old", cap_log[n0], 32'h032F_0000);
        chk("coll_new", cap_log[n0 + 1], 32'h0328_0010);

        // Reset at bit 10 aborts the frame, drops pending, resends init.
        n0 = cap_log.size();
        c0 = cyc;
        send(3'd4, 16'h0000);
        tick(); tick();
        send(3'd6, 16'h1234);
        for (int i = 0; i < 20 && cyc < c0 + 12; i++) tick();
        chk("abort_mid_frame", 32'(n_sync_out), 32'h0);
        reset_in = 1'b1;
        tick();
        chk("abort_sync_high", 32'(n_sync_out), 32'h1);
        tick();
        reset_in = 1'b0;
        wait_idle("abort", 200);
        chk("abort_count", cap_log.size() - n0, 1);
        chk("abort_init", cap_log[cap_log.size() - 1], 32'h0800_0001);

        // Randomized traffic with occasional resets against the model.
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                reset_in = 1'b1;
                repeat (int'($urandom_range(1, 3))) tick();
                reset_in = 1'b0;
            end else if (r < 60) begin
                send(3'($urandom_range(0, 7)), 16'($urandom));
            end else begin
                repeat (int'($urandom_range(1, 20))) tick();
            end
        end
        wait_idle("random", 3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
        $fatal(1);
    end

endmodule
